// File: rtl/fetch_stage_if.sv
// Instruction-memory read port between fetch and the memory.
// One request at a time: req/ready accept, rvalid returns data.
interface fetch_stage_if;
   logic        imem_req;
   logic [9:0]  imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [11:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, reads imem, feeds the FE pipeline register.
// A 1-entry skid buffer absorbs a response that lands during a stall.
module fetch_stage #(
   parameter logic [9:0]  RESET_PC  = 10'h000,
   parameter logic [11:0] NOP_INSTR = 12'h000
) (
   input  logic                 clk,
   input  logic                 rst,
   fetch_stage_if.master        imem,
   input  logic                 stall_in,
   input  logic                 take_branch,
   input  logic [9:0]           next_pc,
   output logic [11:0]          instruction_FE_out,
   output logic [9:0]           pc_plus_1_FE_out,
   output logic                 fe_valid
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_SQUASH
   } state_t;

   state_t      r_state;
   logic [9:0]  r_fetch_pc;
   logic [9:0]  r_req_pc;
   logic        r_buf_valid;
   logic [11:0] r_buf_instr;
   logic [9:0]  r_buf_pc1;
   logic [11:0] r_instr;
   logic [9:0]  r_pc1;
   logic        r_valid;

   logic        w_req;
   logic        w_accept;
   logic        w_deliver;
   logic        w_redirect;
   logic        w_outstanding;
   logic [9:0]  w_dpc1;

   assign w_req      = rst & (r_state == S_REQ) & ~r_buf_valid;
   assign w_accept   = w_req & imem.imem_ready;
   assign w_deliver  = (r_state == S_WAIT) & imem.imem_rvalid;
   assign w_redirect = take_branch & ~stall_in;
   assign w_dpc1     = r_req_pc + 10'd1;

   // A request completing in the redirect cycle needs no squash.
   assign w_outstanding = w_accept |
                          ((r_state != S_REQ) & ~imem.imem_rvalid);

   assign imem.imem_req  = w_req;
   assign imem.imem_addr = r_fetch_pc;

   assign instruction_FE_out = r_instr;
   assign pc_plus_1_FE_out   = r_pc1;
   assign fe_valid           = r_valid;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_REQ;
         r_fetch_pc  <= RESET_PC;
         r_req_pc    <= RESET_PC;
         r_buf_valid <= 1'b0;
         r_buf_instr <= NOP_INSTR;
         r_buf_pc1   <= 10'd0;
         r_instr     <= NOP_INSTR;
         r_pc1       <= 10'd0;
         r_valid     <= 1'b0;
      end else if (w_redirect) begin
         r_fetch_pc  <= next_pc;
         r_buf_valid <= 1'b0;
         r_instr     <= NOP_INSTR;
         r_valid     <= 1'b0;
         r_state     <= w_outstanding ? S_SQUASH : S_REQ;
      end else begin
         unique case (r_state)
            S_REQ: begin
               if (w_accept) begin
                  r_req_pc   <= r_fetch_pc;
                  r_fetch_pc <= r_fetch_pc + 10'd1;
                  r_state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem.imem_rvalid)
                  r_state <= S_REQ;
            end
            S_SQUASH: begin
               if (imem.imem_rvalid)
                  r_state <= S_REQ;
            end
            default: r_state <= S_REQ;
         endcase

         if (stall_in) begin
            if (w_deliver) begin
               r_buf_valid <= 1'b1;
               r_buf_instr <= imem.imem_rdata;
               r_buf_pc1   <= w_dpc1;
            end
         end else if (r_buf_valid) begin
            r_instr     <= r_buf_instr;
            r_pc1       <= r_buf_pc1;
            r_valid     <= 1'b1;
            r_buf_valid <= 1'b0;
         end else if (w_deliver) begin
            r_instr <= imem.imem_rdata;
            r_pc1   <= w_dpc1;
            r_valid <= 1'b1;
         end else begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch pipeline stage that sits directly upstream of the execute stage.
- Owns the 10-bit PC and issues one instruction-memory read at a time over a req/ready + rvalid handshake.
- Registers the fetched 12-bit instruction and its PC+1 into the FE pipeline register that execute consumes.
- Handles downstream stalls with a 1-entry skid buffer, and redirects/squashes on taken branches/jumps.

Parameters:
- RESET_PC, 10'h000, address of the first fetch after reset.
- NOP_INSTR, 12'h000, encoding driven on instruction_FE_out during bubbles; must have no architectural side effects.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-low reset.
- imem_req  out  1  read request.
- imem_addr  out  10  read address; valid while imem_req=1.
- imem_ready  in  1  memory accepts the request when imem_req & imem_ready.
- imem_rvalid  in  1  read data valid, earliest 1 cycle after acceptance.
- imem_rdata  in  12  read data.
- stall_in  in  1  downstream hold; FE register must not change.
- take_branch  in  1  redirect request from execute.
- next_pc  in  10  redirect target.
- instruction_FE_out  out  12  registered instruction.
- pc_plus_1_FE_out  out  10  registered PC of that instruction + 1, mod 1024.
- fe_valid  out  1  FE register holds a real instruction (0 = bubble).

Behaviour:
- Reset (rst=0 at an edge) takes priority over everything:
  - fetch_pc=RESET_PC, state=REQ, buffer empty, squash flag cleared.
  - instruction_FE_out=NOP_INSTR, pc_plus_1_FE_out=0, fe_valid=0.
  - imem_req=0 during any cycle with rst=0.
- State REQ:
  - imem_req=1 and imem_addr=fetch_pc, but only while the skid buffer is empty.
  - On accept (req & ready): record req_pc=fetch_pc, set fetch_pc=fetch_pc+1 (wraps 1023->0), go to WAIT.
  - The address may change only while the request is not yet accepted.
- State WAIT:
  - imem_req=0; at most one request is outstanding.
  - On rvalid: deliver {imem_rdata, req_pc+1}, then go to REQ.
- State SQUASH:
  - Waits for rvalid, discards the data, then goes to REQ. Nothing is delivered.
- Delivery at each edge when stall_in=0 and no redirect, in priority order:
  - Buffer valid: load the FE register from the buffer; fe_valid=1; buffer empty.
  - Else a delivered response: load the FE register; fe_valid=1.
  - Else: bubble (NOP_INSTR, fe_valid=0; pc_plus_1_FE_out holds).
- stall_in=1:
  - FE register holds.
  - A delivered response goes into the buffer.
  - No new request is issued until the buffer drains.
- Redirect: take_branch=1 and stall_in=0 at an edge.
  - fetch_pc=next_pc; FE register becomes a bubble; buffer cleared.
  - Outstanding request (WAIT, or accepted in this same cycle): go to SQUASH.
  - Else: go to REQ.
  - A response arriving in the redirect cycle is discarded.
- take_branch with stall_in=1 is ignored; execute holds the instruction, so the request persists.
- Latency: request accepted at cycle N, rvalid at N+1 -> instruction visible at FE outputs after edge N+1. Throughput is 1 instruction per 2 cycles with a zero-wait memory.
- pc_plus_1 arithmetic is 10-bit and wraps modulo 1024.

Test Plan:
- Reset then straight line: rst=0 for 2 cycles, then mem with ready=1 and rvalid the cycle after accept, rdata=addr+12'h100. Expect FE outputs {12'h100,1}, {12'h101,2}, {12'h102,3}; fe_valid pulses every other cycle; bubbles show NOP_INSTR.
- Wait states: imem_ready low for 3 cycles at addr 5. Expect imem_addr stable at 5 with req=1; a single accept; pc_plus_1_FE_out=6.
- Stall with buffering: stall_in=1 while the FE register holds addr 2 and the response for addr 3 arrives. Expect FE held at {.., 3}, no new req, buffer full. Release stall: FE={rdata3, 4} next edge, then req for 4.
- Branch squash: take_branch=1 with next_pc=10'h040 while the request for 7 is outstanding. Expect bubble, the rvalid for 7 discarded, next imem_addr=10'h040, and FE later shows pc_plus_1=10'h041.
- Wrap and branch under stall: redirect to 10'h3FF, so the fetch yields pc_plus_1_FE_out=0. take_branch asserted with stall_in=1 has no effect on fetch_pc.
- Reset mid-operation: rst=0 while in WAIT. Expect fe_valid=0, imem_req=0, and the next request at RESET_PC once rst=1; a stale rvalid received in REQ after reset is ignored.
